// File: rtl/m2_block_scheduler_if.sv
// Handshake and SRAM bus bundle between the M2 block scheduler and its four sub-units.
// The master side is the scheduler; the slave side is the fetch/CT/CS/write units plus SRAM.
interface m2_block_scheduler_if;
    logic        fetch_start;
    logic        fetch_done;
    logic [17:0] fetch_base;
    logic [8:0]  fetch_stride;
    logic        ct_start;
    logic        ct_done;
    logic        cs_start;
    logic        cs_done;
    logic        write_start;
    logic        write_done;
    logic [17:0] write_base;
    logic [8:0]  write_stride;
    logic [17:0] f_SRAM_address;
    logic [17:0] w_SRAM_address;
    logic [15:0] w_SRAM_write_data;
    logic        w_SRAM_we_n;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    modport master (
        output fetch_start, fetch_base, fetch_stride, ct_start, cs_start,
               write_start, write_base, write_stride,
               SRAM_address, SRAM_write_data, SRAM_we_n,
        input  fetch_done, ct_done, cs_done, write_done,
               f_SRAM_address, w_SRAM_address, w_SRAM_write_data, w_SRAM_we_n
    );

    modport slave (
        input  fetch_start, fetch_base, fetch_stride, ct_start, cs_start,
               write_start, write_base, write_stride,
               SRAM_address, SRAM_write_data, SRAM_we_n,
        output fetch_done, ct_done, cs_done, write_done,
               f_SRAM_address, w_SRAM_address, w_SRAM_write_data, w_SRAM_we_n
    );
endinterface

// File: rtl/m2_block_scheduler.sv
// Milestone 2 IDCT top-level sequencer: walks all Y/U/V 8x8 blocks, overlapping
// Fetch(n+1)||CT(n) and CS(n)||Write(n-1), and muxes the single SRAM port.
module m2_block_scheduler #(
    parameter int unsigned Y_COLS      = 40,
    parameter int unsigned Y_ROWS      = 30,
    parameter int unsigned UV_COLS     = 20,
    parameter int unsigned UV_ROWS     = 30,
    parameter logic [17:0] PRE_Y_BASE  = 18'd76800,
    parameter logic [17:0] POST_Y_BASE = 18'd0
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic Enable,
    output logic Done,
    m2_block_scheduler_if.master bus
);
    localparam int unsigned N_BLOCKS = Y_COLS * Y_ROWS + 2 * UV_COLS * UV_ROWS;

    // Plane bases follow from plane sizes: 64 samples/block pre-IDCT, 32 words/block post-IDCT.
    localparam logic [17:0] PRE_U_BASE  = PRE_Y_BASE  + 18'(Y_COLS * Y_ROWS * 64);
    localparam logic [17:0] PRE_V_BASE  = PRE_U_BASE  + 18'(UV_COLS * UV_ROWS * 64);
    localparam logic [17:0] POST_U_BASE = POST_Y_BASE + 18'(Y_COLS * Y_ROWS * 32);
    localparam logic [17:0] POST_V_BASE = POST_U_BASE + 18'(UV_COLS * UV_ROWS * 32);
    localparam logic [8:0]  PRE_Y_STRIDE   = 9'(Y_COLS * 8);
    localparam logic [8:0]  PRE_UV_STRIDE  = 9'(UV_COLS * 8);
    localparam logic [8:0]  POST_Y_STRIDE  = 9'(Y_COLS * 4);
    localparam logic [8:0]  POST_UV_STRIDE = 9'(UV_COLS * 4);
    localparam logic [7:0]  Y_LAST_COL  = 8'(Y_COLS - 1);
    localparam logic [7:0]  Y_LAST_ROW  = 8'(Y_ROWS - 1);
    localparam logic [7:0]  UV_LAST_COL = 8'(UV_COLS - 1);
    localparam logic [7:0]  UV_LAST_ROW = 8'(UV_ROWS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LEAD_IN  = 3'd1;
    localparam logic [2:0] S_MS_A     = 3'd2;
    localparam logic [2:0] S_MS_B     = 3'd3;
    localparam logic [2:0] S_LEAD_OUT = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    typedef struct packed {
        logic [1:0]  plane;
        logic [7:0]  brow;
        logic [7:0]  bcol;
        logic [17:0] row_base;
        logic [17:0] base;
        logic [8:0]  stride;
    } ptr_t;

    function automatic logic [17:0] plane_base(input logic pre, input logic [1:0] p);
        case (p)
            2'd0:    return pre ? PRE_Y_BASE : POST_Y_BASE;
            2'd1:    return pre ? PRE_U_BASE : POST_U_BASE;
            default: return pre ? PRE_V_BASE : POST_V_BASE;
        endcase
    endfunction

    function automatic logic [8:0] plane_stride(input logic pre, input logic [1:0] p);
        if (p == 2'd0) return pre ? PRE_Y_STRIDE : POST_Y_STRIDE;
        return pre ? PRE_UV_STRIDE : POST_UV_STRIDE;
    endfunction

    function automatic ptr_t first_block(input logic pre);
        ptr_t q;
        q          = '0;
        q.row_base = plane_base(pre, 2'd0);
        q.base     = q.row_base;
        q.stride   = plane_stride(pre, 2'd0);
        return q;
    endfunction

    // Row step is stride*8 as a shift; column step is 8 samples pre-IDCT, 4 words post-IDCT.
    function automatic ptr_t advance(input ptr_t p, input logic pre);
        ptr_t q;
        q = p;
        if (p.bcol != ((p.plane == 2'd0) ? Y_LAST_COL : UV_LAST_COL)) begin
            q.bcol = p.bcol + 8'd1;
            q.base = p.base + (pre ? 18'd8 : 18'd4);
        end else if (p.brow != ((p.plane == 2'd0) ? Y_LAST_ROW : UV_LAST_ROW)) begin
            q.bcol     = '0;
            q.brow     = p.brow + 8'd1;
            q.row_base = p.row_base + {6'd0, p.stride, 3'd0};
            q.base     = q.row_base;
        end else begin
            q.bcol     = '0;
            q.brow     = '0;
            q.plane    = p.plane + 2'd1;
            q.row_base = plane_base(pre, q.plane);
            q.base     = q.row_base;
            q.stride   = plane_stride(pre, q.plane);
        end
        return q;
    endfunction

    logic [2:0]  state, state_n;
    logic [15:0] blk;
    // Unit vectors: [3] fetch, [2] compute T, [1] compute S, [0] write.
    logic [3:0]  need, need_n, got, starts, dones;
    logic        all_done, more_1, more_2;
    ptr_t        fptr, wptr;

    assign dones    = {bus.fetch_done, bus.ct_done, bus.cs_done, bus.write_done};
    assign all_done = &(~need | got | dones);
    assign more_1   = (32'(blk) + 32'd1) < N_BLOCKS;
    assign more_2   = (32'(blk) + 32'd2) < N_BLOCKS;

    always_comb begin
        state_n = state;
        need_n  = '0;
        case (state)
            S_IDLE: if (Enable) begin
                state_n = S_LEAD_IN;
                need_n  = 4'b1000;
            end
            S_LEAD_IN: if (all_done) begin
                state_n = S_MS_A;
                need_n  = {more_1, 1'b1, 2'b00};
            end
            S_MS_A: if (all_done) begin
                state_n = S_MS_B;
                need_n  = {2'b00, 1'b1, blk != 16'd0};
            end
            S_MS_B: if (all_done) begin
                if (more_1) begin
                    state_n = S_MS_A;
                    need_n  = {more_2, 1'b1, 2'b00};
                end else begin
                    state_n = S_LEAD_OUT;
                    need_n  = 4'b0001;
                end
            end
            S_LEAD_OUT: if (all_done) state_n = S_DONE;
            S_DONE:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    // Every transition changes state, so state_n != state marks entry into a new state.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= S_IDLE;
            blk    <= '0;
            need   <= '0;
            got    <= '0;
            starts <= '0;
            fptr   <= '0;
            wptr   <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && Enable) begin
                fptr <= first_block(1'b1);
                wptr <= first_block(1'b0);
                blk  <= '0;
            end
            if (all_done && need[3]) fptr <= advance(fptr, 1'b1);
            if (all_done && need[0]) wptr <= advance(wptr, 1'b0);
            if (state == S_MS_B && state_n == S_MS_A) blk <= blk + 16'd1;
            if (state_n != state) begin
                need   <= need_n;
                starts <= need_n;
                got    <= '0;
            end else begin
                starts <= '0;
                got    <= got | (dones & need);
            end
        end
    end

    assign Done             = (state == S_DONE);
    assign bus.fetch_start  = starts[3];
    assign bus.ct_start     = starts[2];
    assign bus.cs_start     = starts[1];
    assign bus.write_start  = starts[0];
    assign bus.fetch_base   = fptr.base;
    assign bus.fetch_stride = fptr.stride;
    assign bus.write_base   = wptr.base;
    assign bus.write_stride = wptr.stride;

    always_comb begin
        bus.SRAM_address    = '0;
        bus.SRAM_write_data = '0;
        bus.SRAM_we_n       = 1'b1;
        case (state)
            S_LEAD_IN, S_MS_A: bus.SRAM_address = bus.f_SRAM_address;
            S_MS_B, S_LEAD_OUT: begin
                bus.SRAM_address    = bus.w_SRAM_address;
                bus.SRAM_write_data = bus.w_SRAM_write_data;
                bus.SRAM_we_n       = bus.w_SRAM_we_n;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_m2_block_scheduler.sv
// Bench for m2_block_scheduler: delay-programmable sub-unit stubs and a phase-list
// reference model of the whole frame schedule and address sequence.
module tb_m2_block_scheduler;
    localparam int NB = 2400;

    logic Clock = 1'b0;
    logic Resetn;
    logic Enable;
    logic Done;

    m2_block_scheduler_if bus();

    m2_block_scheduler dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Enable (Enable),
        .Done   (Done),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int unsigned cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Stub and snapshot state; unit bit order [3] fetch, [2] CT, [1] CS, [0] write.
    int unsigned dly_lo [4];
    int unsigned dly_hi [4];
    int          cnt    [4];
    bit          rand_sram = 1'b0;
    bit          spur_w    = 1'b0;
    int unsigned prev_done = 0;
    int unsigned s_cyc;
    logic [3:0]  s_st;
    logic        s_done, s_we, s_wwe;
    logic [17:0] s_fb, s_wb, s_addr, s_fa, s_wa;
    logic [8:0]  s_fs, s_ws;
    logic [15:0] s_data, s_wd;

    typedef struct {
        int f;
        int c;
        int s;
        int w;
    } phase_t;

    function automatic logic [17:0] exp_base(input int k, input bit pre);
        int cols, pb, idx;
        if (k < 1200) begin
            idx = k;        cols = 40; pb = pre ? 76800  : 0;
        end else if (k < 1800) begin
            idx = k - 1200; cols = 20; pb = pre ? 153600 : 38400;
        end else begin
            idx = k - 1800; cols = 20; pb = pre ? 192000 : 57600;
        end
        return 18'(pb + (idx / cols) * 8 * (cols * (pre ? 8 : 4)) + (idx % cols) * (pre ? 8 : 4));
    endfunction

    function automatic logic [8:0] exp_stride(input int k, input bit pre);
        return 9'(((k < 1200) ? 40 : 20) * (pre ? 8 : 4));
    endfunction

    task automatic tick();
        logic [3:0] dn;
        @(negedge Clock);
        s_cyc  = cyc;
        s_st   = {bus.fetch_start, bus.ct_start, bus.cs_start, bus.write_start};
        s_done = Done;
        s_fb   = bus.fetch_base;  s_fs = bus.fetch_stride;
        s_wb   = bus.write_base;  s_ws = bus.write_stride;
        s_addr = bus.SRAM_address; s_data = bus.SRAM_write_data; s_we = bus.SRAM_we_n;
        s_fa   = bus.f_SRAM_address; s_wa = bus.w_SRAM_address;
        s_wd   = bus.w_SRAM_write_data; s_wwe = bus.w_SRAM_we_n;
        dn = '0;
        for (int b = 0; b < 4; b++) begin
            if (cnt[b] > 0) begin
                cnt[b]--;
                if (cnt[b] == 0) dn[b] = 1'b1;
            end
            if (s_st[b]) cnt[b] = int'($urandom_range(dly_hi[b], dly_lo[b]));
        end
        if (dn != 4'b0000) prev_done = s_cyc;
        if (spur_w) dn[0] = 1'b1;
        spur_w = 1'b0;
        bus.fetch_done = dn[3];
        bus.ct_done    = dn[2];
        bus.cs_done    = dn[1];
        bus.write_done = dn[0];
        if (rand_sram) begin
            bus.f_SRAM_address    = 18'($urandom);
            bus.w_SRAM_address    = 18'($urandom);
            bus.w_SRAM_write_data = 16'($urandom);
            bus.w_SRAM_we_n       = 1'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [3:0] st;
        st = {bus.fetch_start, bus.ct_start, bus.cs_start, bus.write_start};
        total++;
        if (st !== 4'b0000 || Done !== 1'b0 || bus.fetch_base !== 18'd0 || bus.fetch_stride !== 9'd0 ||
            bus.write_base !== 18'd0 || bus.write_stride !== 9'd0 || bus.SRAM_we_n !== 1'b1 ||
            bus.SRAM_address !== 18'd0 || bus.SRAM_write_data !== 16'd0)
            $display("FAIL %s: starts=%b done=%b fb=%0d fs=%0d wb=%0d ws=%0d we_n=%b addr=%h data=%h, required all zero with we_n=1",
                     tag, st, Done, bus.fetch_base, bus.fetch_stride, bus.write_base, bus.write_stride,
                     bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data);
        else passed++;
    endtask

    task automatic test_reset();
        for (int b = 0; b < 4; b++) begin cnt[b] = 0; dly_lo[b] = 1; dly_hi[b] = 1; end
        Resetn = 1'b0; Enable = 1'b0;
        bus.fetch_done = 0; bus.ct_done = 0; bus.cs_done = 0; bus.write_done = 0;
        bus.f_SRAM_address = 18'h2ABCD; bus.w_SRAM_address = 18'h1234;
        bus.w_SRAM_write_data = 16'hBEEF; bus.w_SRAM_we_n = 1'b0;
        tick(); tick();
        check_reset_outputs("reset_state");
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (s_st !== 4'b0000 || s_done !== 1'b0 || s_we !== 1'b1)
            $display("FAIL idle_after_reset: starts=%b done=%b we_n=%b, required 0000/0/1", s_st, s_done, s_we);
        else passed++;
    endtask

    // Fixed delays fetch=3, ct=9, cs=4, write=4; Enable held high; spurious write_done in every A.
    task automatic test_overlap_timing();
        int unsigned k = 0, t_prev = 0, t_a = 0, budget = 0, gap;
        logic [3:0]  exp;
        bit          fside;
        dly_lo[3] = 3; dly_hi[3] = 3; dly_lo[2] = 9; dly_hi[2] = 9;
        dly_lo[1] = 4; dly_hi[1] = 4; dly_lo[0] = 4; dly_hi[0] = 4;
        rand_sram = 1'b0;
        Enable = 1'b1;
        while (k < 16 && budget < 600) begin
            tick(); budget++;
            if (s_st != 4'b0000) begin
                exp = (k == 0) ? 4'b1000 : (k % 2 == 1) ? 4'b1100 : (k == 2) ? 4'b0010 : 4'b0011;
                total++;
                if (s_st !== exp) $display("FAIL phase_starts[%0d]: got %b, required %b", k, s_st, exp);
                else passed++;
                if (k > 0) begin
                    gap = (k == 1) ? 4 : (k % 2 == 0) ? 10 : 5;
                    total++;
                    if (s_cyc - t_prev !== gap)
                        $display("FAIL phase_gap[%0d]: got %0d cycles, required %0d", k, s_cyc - t_prev, gap);
                    else passed++;
                end
                t_prev = s_cyc;
                if (k % 2 == 1) t_a = s_cyc;
                k++;
            end
            if (k > 0) begin
                fside = ((k - 1) % 2 == 1) || (k == 1);
                total++;
                if (fside && (s_addr !== 18'h2ABCD || s_we !== 1'b1))
                    $display("FAIL mux_fetch_side[%0d]: addr=%h we_n=%b, required 2abcd/1", k - 1, s_addr, s_we);
                else if (!fside && (s_addr !== 18'h1234 || s_we !== 1'b0 || s_data !== 16'hBEEF))
                    $display("FAIL mux_write_side[%0d]: addr=%h we_n=%b data=%h, required 01234/0/beef",
                             k - 1, s_addr, s_we, s_data);
                else passed++;
                if (fside && k > 1 && s_cyc == t_a + 1) spur_w = 1'b1;
            end
        end
        total++;
        if (k < 16) $display("FAIL timing_timeout: reached phase %0d, required 16", k);
        else passed++;
    endtask

    task automatic test_midframe_reset();
        tick(); tick();
        Resetn = 1'b0; Enable = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        tick(); tick();
        Resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (s_st !== 4'b0000 || s_done !== 1'b0)
                $display("FAIL no_start_after_reset[%0d]: starts=%b done=%b, required 0000/0", i, s_st, s_done);
            else passed++;
        end
    endtask

    task automatic test_full_frame();
        phase_t      q[$];
        phase_t      ph;
        int unsigned pidx = 0, budget = 0;
        int unsigned nstart [4];
        bit          seen_done = 1'b0, in_frame = 1'b0, wside = 1'b0;
        logic [3:0]  exp;
        q.push_back('{0, -1, -1, -1});
        for (int n = 0; n < NB; n++) begin
            q.push_back('{(n + 1 < NB) ? n + 1 : -1, n, -1, -1});
            q.push_back('{-1, -1, n, (n >= 1) ? n - 1 : -1});
        end
        q.push_back('{-1, -1, -1, NB - 1});
        for (int b = 0; b < 4; b++) begin nstart[b] = 0; dly_lo[b] = 1; dly_hi[b] = 6; end
        rand_sram = 1'b1;
        Enable = 1'b1;
        while (!seen_done && budget < 60000) begin
            tick(); budget++;
            if (pidx >= q.size()) Enable = 1'b0;
            else if (budget > 8) Enable = ($urandom_range(0, 99) == 0);
            if (s_st != 4'b0000) begin
                for (int b = 0; b < 4; b++) nstart[b] += s_st[b];
                total++;
                if (pidx >= q.size()) begin
                    $display("FAIL extra_start: starts=%b at cycle %0d after the last phase", s_st, s_cyc);
                end else begin
                    ph  = q[pidx];
                    exp = {ph.f >= 0, ph.c >= 0, ph.s >= 0, ph.w >= 0};
                    if (s_st !== exp) $display("FAIL frame_starts[%0d]: got %b, required %b", pidx, s_st, exp);
                    else passed++;
                    if (ph.f >= 0) begin
                        total++;
                        if (s_fb !== exp_base(ph.f, 1'b1) || s_fs !== exp_stride(ph.f, 1'b1))
                            $display("FAIL fetch_addr[blk %0d]: base=%0d stride=%0d, required %0d/%0d",
                                     ph.f, s_fb, s_fs, exp_base(ph.f, 1'b1), exp_stride(ph.f, 1'b1));
                        else passed++;
                    end
                    if (ph.w >= 0) begin
                        total++;
                        if (s_wb !== exp_base(ph.w, 1'b0) || s_ws !== exp_stride(ph.w, 1'b0))
                            $display("FAIL write_addr[blk %0d]: base=%0d stride=%0d, required %0d/%0d",
                                     ph.w, s_wb, s_ws, exp_base(ph.w, 1'b0), exp_stride(ph.w, 1'b0));
                        else passed++;
                    end
                    if (pidx > 0) begin
                        total++;
                        if (s_cyc !== prev_done + 1)
                            $display("FAIL frame_gap[%0d]: start cycle %0d, required %0d", pidx, s_cyc, prev_done + 1);
                        else passed++;
                    end
                    wside    = (ph.s >= 0) || (ph.w >= 0);
                    in_frame = 1'b1;
                    pidx++;
                end
            end
            if (s_done) begin
                total++;
                if (pidx != q.size() || s_cyc !== prev_done + 1 || s_addr !== 18'd0 || s_we !== 1'b1)
                    $display("FAIL done_pulse: phase %0d/%0d cycle %0d (required %0d) addr=%h we_n=%b",
                             pidx, q.size(), s_cyc, prev_done + 1, s_addr, s_we);
                else passed++;
                seen_done = 1'b1;
                in_frame  = 1'b0;
            end
            if (in_frame) begin
                total++;
                if (wside && (s_addr !== s_wa || s_data !== s_wd || s_we !== s_wwe))
                    $display("FAIL frame_mux_write[%0d]: addr=%h data=%h we_n=%b, required %h/%h/%b",
                             pidx - 1, s_addr, s_data, s_we, s_wa, s_wd, s_wwe);
                else if (!wside && (s_addr !== s_fa || s_we !== 1'b1))
                    $display("FAIL frame_mux_fetch[%0d]: addr=%h we_n=%b, required %h/1", pidx - 1, s_addr, s_we, s_fa);
                else passed++;
            end
        end
        total++;
        if (!seen_done) $display("FAIL frame_timeout: no Done within %0d cycles, phase %0d", budget, pidx);
        else passed++;
        for (int b = 0; b < 4; b++) begin
            total++;
            if (nstart[b] !== NB) $display("FAIL start_count[unit %0d]: got %0d, required %0d", b, nstart[b], NB);
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (s_done !== 1'b0 || s_st !== 4'b0000)
                $display("FAIL idle_after_done[%0d]: done=%b starts=%b, required 0/0000", i, s_done, s_st);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_overlap_timing();
        test_midframe_reset();
        test_full_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
